// File: rtl/seg_pkg.sv
// Shared types and constants for the segment display path (mapper and serial driver).
package seg_pkg;

   localparam int SEG_BITS = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } seg_state_e;

endpackage

// File: rtl/seg_sclk_gen.sv
// Serial clock phase generator: alternating rise/fall ticks every SCLK_HALF cycles.
module seg_sclk_gen #(
   parameter int SCLK_HALF = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int            PW     = $clog2(SCLK_HALF + 1);
   localparam logic [PW-1:0] RELOAD = PW'(SCLK_HALF - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic          high_q, high_d;
   logic          tc;

   assign tc = (phase_q == '0);

   always_comb begin
      phase_d = phase_q;
      high_d  = high_q;
      if (clr_i) begin
         phase_d = RELOAD;
         high_d  = 1'b0;
      end else if (en_i) begin
         if (tc) begin
            phase_d = RELOAD;
            high_d  = ~high_q;
         end else begin
            phase_d = phase_q - PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= RELOAD;
         high_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         high_q  <= high_d;
      end
   end

   assign rise_tick_o = en_i & ~clr_i & tc & ~high_q;
   assign fall_tick_o = en_i & ~clr_i & tc &  high_q;

endmodule

// File: rtl/seg_serial_driver.sv
// MSB-first parallel-to-serial driver for the 74HC164-style display chain.
// Optional SEG_AUTO_REFRESH_EN: relaunch a frame whenever par_data differs from the last frame sent.
//
// state    | meaning
// ST_IDLE  | waiting for start (or a changed map when auto refresh is built in)
// ST_SHIFT | shifting bits out, 2*SCLK_HALF cycles per bit
// ST_LATCH | s_en strobe for SCLK_HALF cycles, s_dout holds bit 0
module seg_serial_driver
   import seg_pkg::*;
#(
   parameter int DATA_BITS = SEG_BITS,
   parameter int SCLK_HALF = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] par_data,
   output logic                 busy,
   output logic                 done,
   output logic                 s_clk,
   output logic                 s_dout,
   output logic                 s_clr_n,
   output logic                 s_en
);

   localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   seg_state_e           state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 sclk_q, sclk_d;
   logic                 en_q, en_d;
   logic                 done_q, done_d;
   logic                 clr_q;
   logic                 launch;
   logic                 rise_tick, fall_tick;

`ifdef SEG_AUTO_REFRESH_EN
   logic [DATA_BITS-1:0] snap_q;
   logic                 first_q;

   // first_q forces one refresh after reset regardless of the map contents
   assign launch = (state_q == ST_IDLE) & (start | first_q | (par_data != snap_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q  <= '0;
         first_q <= 1'b1;
      end else if (launch) begin
         snap_q  <= par_data;
         first_q <= 1'b0;
      end
   end
`else
   assign launch = (state_q == ST_IDLE) & start;
`endif

   seg_sclk_gen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_sclk_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (state_q != ST_IDLE),
      .clr_i       (launch),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      sclk_d    = sclk_q;
      en_d      = en_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d   = ST_SHIFT;
               shreg_d   = par_data;
               bit_cnt_d = LAST_BIT;
               sclk_d    = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (rise_tick) begin
               sclk_d = 1'b1;
            end else if (fall_tick) begin
               sclk_d = 1'b0;
               // last bit is not shifted out so s_dout keeps bit 0 through the latch
               if (bit_cnt_q == '0) begin
                  state_d = ST_LATCH;
                  en_d    = 1'b1;
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q - BW'(1);
               end
            end
         end
         ST_LATCH: begin
            if (rise_tick) begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         sclk_q    <= sclk_d;
         en_q      <= en_d;
         done_q    <= done_d;
         clr_q     <= 1'b1;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign s_clk   = sclk_q;
   assign s_dout  = shreg_q[DATA_BITS-1];
   assign s_en    = en_q;
   assign s_clr_n = clr_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Randomized self-checking bench for seg_serial_driver against a frame-level reference model.
module tb_seg_serial_driver;

   localparam int DB     = 64;
   localparam int H      = 2;
   localparam int SH_CYC = 2 * H * DB;
   localparam int WIN    = SH_CYC + H + 1 + 20;
`ifdef SEG_AUTO_REFRESH_EN
   localparam int EXP_AUTO = 1;
`else
   localparam int EXP_AUTO = 0;
`endif

   logic          clk, rst_n, start;
   logic [DB-1:0] par_data;
   logic          busy, done, s_clk, s_dout, s_clr_n, s_en;

   int checks   = 0;
   int failures = 0;

   seg_serial_driver #(
      .DATA_BITS (DB),
      .SCLK_HALF (H)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .par_data (par_data),
      .busy     (busy),
      .done     (done),
      .s_clk    (s_clk),
      .s_dout   (s_dout),
      .s_clr_n  (s_clr_n),
      .s_en     (s_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Watch the pins for ncyc cycles: frames = busy rising edges, bits = s_dout at s_clk rises.
   task automatic count_frames(input int ncyc, output int frames, output int rises,
                               output logic [63:0] bits);
      logic pb, pc;
      pb = 1'b0; pc = 1'b0;
      frames = 0; rises = 0; bits = '0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (busy && !pb) frames++;
         if (s_clk && !pc) begin
            rises++;
            bits = {bits[62:0], s_dout};
         end
         pb = busy;
         pc = s_clk;
      end
   endtask

   // One frame launched by start; cycle n is the n-th cycle after the accepting edge.
   task automatic do_frame(input logic [63:0] d, input bit disturb, input logic [63:0] alt,
                           input string tag);
      int rises, bad_rise, en_cnt, en_bad, busy_cnt, done_cnt, done_at;
      logic [63:0] obs;
      logic prev_clk, b1, dout_latch;
      rises = 0; bad_rise = 0; en_cnt = 0; en_bad = 0; busy_cnt = 0;
      done_cnt = 0; done_at = -1; obs = '0; prev_clk = 1'b0; b1 = 1'b0; dout_latch = 1'b0;
      @(negedge clk);
      par_data = d;
      start    = 1'b1;
      for (int n = 1; n <= WIN; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (disturb) begin
            if (n == 10) begin start = 1'b1; par_data = '1; end
            if (n == 11) begin start = 1'b0; par_data = d; end
            if (n == 50) par_data = alt;
            if (n == 200) par_data = d;
         end
         if (n == 1) b1 = busy;
         if (busy) busy_cnt++;
         if (s_en) begin
            en_cnt++;
            if (n < SH_CYC + 1 || n > SH_CYC + H) en_bad++;
         end
         if (n == SH_CYC + 1) dout_latch = s_dout;
         if (done) begin done_cnt++; done_at = n; end
         if (s_clk && !prev_clk) begin
            if (n != H * (2 * rises + 1) + 1) bad_rise++;
            obs = {obs[62:0], s_dout};
            rises++;
         end
         prev_clk = s_clk;
      end
      chk({tag, "_busy1"},     64'(b1),       64'd1);
      chk({tag, "_rises"},     64'(rises),    64'(DB));
      chk({tag, "_bits"},      obs,           d);
      chk({tag, "_rise_time"}, 64'(bad_rise), 64'd0);
      chk({tag, "_en_len"},    64'(en_cnt),   64'(H));
      chk({tag, "_en_place"},  64'(en_bad),   64'd0);
      chk({tag, "_dout_latch"},64'(dout_latch),64'(d[0]));
      chk({tag, "_done_cnt"},  64'(done_cnt), 64'd1);
      chk({tag, "_done_at"},   64'(done_at),  64'(SH_CYC + H + 1));
      chk({tag, "_busy_len"},  64'(busy_cnt), 64'(SH_CYC + H));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(tag, {58'd0, busy, done, s_clk, s_dout, s_en, s_clr_n}, 64'd0);
   endtask

   initial begin
      int f, r, waited;
      logic [63:0] b, d1, d2;
      bit found;
      rst_n = 1'b0; start = 1'b0; par_data = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_hold");

      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("clr_before_edge", 64'(s_clr_n), 64'd0);
      @(negedge clk);
      chk("clr_after_edge", 64'(s_clr_n), 64'd1);
      count_frames(400, f, r, b);
      chk("post_reset_frames", 64'(f), 64'(EXP_AUTO));
      chk("post_reset_rises",  64'(r), 64'(EXP_AUTO * DB));

      @(negedge clk);
      par_data = 64'h1234_5678_9ABC_DEF0;
      count_frames(400, f, r, b);
      chk("map_change_frames", 64'(f), 64'(EXP_AUTO));
      chk("map_change_bits",   b, (EXP_AUTO != 0) ? 64'h1234_5678_9ABC_DEF0 : 64'd0);
      count_frames(400, f, r, b);
      chk("map_hold_frames", 64'(f), 64'd0);

      do_frame(64'h8000_0000_0000_0001, 1'b0, 64'd0, "ends");
      do_frame(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'd0, "disturb");
      for (int k = 0; k < 6; k++) begin
         d1 = {$urandom, $urandom};
         do_frame(d1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $sformatf("rnd%0d", k));
      end

      // start in the done cycle must be accepted
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      found = 1'b0;
      @(negedge clk);
      par_data = d1;
      start    = 1'b1;
      for (int n = 1; n <= WIN && !found; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            found    = 1'b1;
            start    = 1'b1;
            par_data = d2;
         end
      end
      chk("b2b_done_seen", 64'(found), 64'd1);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'(found));
      count_frames(400, f, r, b);
      chk("b2b_frames", 64'(f), 64'd1);
      chk("b2b_bits",   b, d2);

      // async reset in the middle of a frame
      @(negedge clk);
      par_data = {$urandom, $urandom};
      start    = 1'b1;
      waited   = 0;
      repeat (100) begin
         @(negedge clk);
         start = 1'b0;
         waited++;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("abort_outputs");
      @(negedge clk);
      check_reset_outputs("abort_hold");
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_clr", 64'(s_clr_n), 64'd1);
      count_frames(400, f, r, b);
      chk("abort_frames", 64'(f), 64'(EXP_AUTO));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
